ifu_idu_queue: RTL and testbench
================================

// Module: ifu_idu_queue
// PURPOSE
//  Parametrised IFU->IDU instruction queue replacing the single-entry fetch/decode register.
//  Buffers up to DEPTH fetched instructions with a valid/ready handshake on both sides and a flush.
//  Decouples fetch from decode stalls so fetch keeps running while decode is back-pressured.
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  INST_W  32  instruction width
//  ADDR_W  32  instruction address width
// PORTS
//  clk            in   1                    clock; all state updates on rising edge
//  rst            in   1                    synchronous reset, active-high
//  flush_i        in   1                    discard all entries and the current input
//  in_valid_i     in   1                    IFU presents an instruction
//  in_ready_o     out  1                    queue accepts an instruction
//  in_inst_i      in   INST_W               instruction word
//  in_addr_i      in   ADDR_W               instruction address
//  out_valid_o    out  1                    head entry valid for IDU
//  out_ready_i    in   1                    IDU consumes the head this cycle
//  out_inst_o     out  INST_W               head instruction; INST_NOP when !out_valid_o
//  out_addr_o     out  ADDR_W               head address; 0 when !out_valid_o
//  count_o        out  $clog2(DEPTH+1)      current occupancy
// BEHAVIOUR
//  - Reset and flush take effect at the next clock edge: wr_ptr = rd_ptr = 0, count_o = 0, out_valid_o = 0,
//    out_inst_o = INST_NOP, out_addr_o = 0. Storage contents are not cleared.
//  - in_ready_o = (count_o != DEPTH). Combinational; independent of out_ready_i.
//  - push = in_valid_i & in_ready_o & !flush_i; pop = out_valid_o & out_ready_i & !flush_i.
//  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full
//    only if a pop occurs, but in_ready_o stays 0 when full (no pass-through when full).
//  - Pointers are $clog2(DEPTH)+1 bits wide with a wrap bit. Full = MSBs differ and LSBs equal.
//    Pointers wrap naturally modulo 2*DEPTH.
//  - The head is read combinationally from storage[rd_ptr]. out_valid_o = (count_o != 0).
//  - Default latency: an instruction pushed in cycle N is visible at the output in cycle N+1.
//  - flush_i has priority over push, pop and the bypass path in the same cycle. Input is dropped,
//    head is not consumed, and out_valid_o is low from the next cycle.
//  - Order is strictly FIFO; no entry is duplicated or reordered.
//  - in_* is ignored when in_valid_i = 0. out_ready_i is ignored when out_valid_o = 0.
// CONFIGURATION
//  IFU_IDU_BYPASS_EN defined:
//    - When the queue is empty and !flush_i, out_* = in_* combinationally and out_valid_o = in_valid_i.
//    - If out_ready_i = 1, the instruction is consumed without being written (0-cycle latency).
//    - Otherwise it is pushed normally.
//  IFU_IDU_BYPASS_EN undefined:
//    - Registered path only; minimum latency 1 cycle. No combinational path from in_* to out_*.
// STRUCTURE
//  - Package ifu_idu_pkg:
//      - INST_NOP constant (32'h00000013).
//      - typedef struct packed {inst, addr} ifu_idu_entry_t.
//      - Pointer width function ptr_w(DEPTH).
//  - Sub-module ifu_idu_qmem: DEPTH x (INST_W+ADDR_W) register array.
//      - One synchronous write port (we, waddr, wdata); one async read port.
//      - No reset on the array.
//  - Top level holds pointers, count, flush/reset logic and the bypass mux.
// TESTING
//  1. Reset mid-fill: push 3 entries (DEPTH=4), assert rst for 1 cycle -> count_o=0, out_valid_o=0,
//     out_inst_o=32'h13, in_ready_o=1.
//  2. Fill and backpressure: out_ready_i=0, push 0x1000..0x100C -> count_o=4, in_ready_o=0.
//     Then raise out_ready_i -> addresses pop in order 0x1000,0x1004,0x1008,0x100C.
//  3. Wrap: continuous push+pop for 10 cycles at count 2 -> count_o stays 2, output addresses
//     increment by 4 with no gaps across pointer wrap.
//  4. Flush with simultaneous push and pop at count 3 -> next cycle count_o=0, out_valid_o=0,
//     flushed input never appears at the output.
//  5. Latency: empty queue, push 0x2000 with out_ready_i=1 -> without IFU_IDU_BYPASS_EN it appears
//     1 cycle later; with it, out_valid_o=1 the same cycle and count_o stays 0.
//  6. Full simultaneous: count_o=4, out_ready_i=1, in_valid_i=1 -> pop occurs, input not accepted
//     (in_ready_o=0), count_o=3.

Source files
------------

// File: rtl/ifu_idu_pkg.sv
// ifu_idu_pkg: shared constants and types for the IFU->IDU instruction queue.
//   INST_NOP         instruction presented on the output when nothing is valid
//   ifu_idu_entry_t  one queue entry (instruction word + address) at 32/32 widths
//   ptr_w()          pointer width for a queue of a given depth (index bits + wrap bit)
package ifu_idu_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ifu_idu_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_idu_qmem.sv
// ifu_idu_qmem: DEPTH x W register array backing the IFU->IDU queue.
// One synchronous write port and one asynchronous read port. The array is
// deliberately not reset; the queue's pointers decide what is valid.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   write data
//   i_raddr  in   read index
//   o_rdata  out  read data (combinational)
module ifu_idu_qmem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifu_idu_queue.sv
// ifu_idu_queue: parametrised IFU->IDU instruction queue with valid/ready on
// both sides and a flush. Lets fetch keep running while decode is stalled.
// Optional feature macro: IFU_IDU_BYPASS_EN (empty-queue combinational bypass).
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   flush_i      in   drop all entries and the current input
//   in_valid_i   in   IFU presents an instruction
//   in_ready_o   out  queue can accept (not full)
//   in_inst_i    in   instruction word
//   in_addr_i    in   instruction address
//   out_valid_o  out  head valid for IDU
//   out_ready_i  in   IDU consumes the head
//   out_inst_o   out  head instruction, INST_NOP when not valid
//   out_addr_o   out  head address, 0 when not valid
//   count_o      out  current occupancy
module ifu_idu_queue
  import ifu_idu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INST_W-1:0]          in_inst_i,
  input  logic [ADDR_W-1:0]          in_addr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [INST_W-1:0]          out_inst_o,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = INST_W + ADDR_W;
  localparam logic [INST_W-1:0] NOP = INST_W'(INST_NOP);

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     w_diff;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_byp_take;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [EW-1:0]     w_rdata;
  logic [INST_W-1:0] w_head_inst;
  logic [ADDR_W-1:0] w_head_addr;

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign w_diff  = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign count_o    = CW'(w_diff);
  assign in_ready_o = !w_full;

  assign w_push  = in_valid_i & !w_full & !flush_i;
  assign w_rd_en = !w_empty & out_ready_i & !flush_i;

`ifdef IFU_IDU_BYPASS_EN
  // An instruction that arrives at an empty queue and is taken the same
  // cycle never touches storage.
  assign w_byp_take = w_empty & in_valid_i & out_ready_i & !flush_i;
`else
  assign w_byp_take = 1'b0;
`endif

  assign w_wr_en = w_push & !w_byp_take & !rst;

  ifu_idu_qmem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_qmem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata ({in_inst_i, in_addr_i}),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign w_head_inst = w_rdata[EW-1 -: INST_W];
  assign w_head_addr = w_rdata[ADDR_W-1:0];

  always_comb begin
    out_valid_o = !w_empty;
    out_inst_o  = w_empty ? NOP : w_head_inst;
    out_addr_o  = w_empty ? '0  : w_head_addr;
`ifdef IFU_IDU_BYPASS_EN
    // Flush suppresses the bypass; the registered view (empty) is shown.
    if (w_empty && !flush_i) begin
      out_valid_o = in_valid_i;
      out_inst_o  = in_valid_i ? in_inst_i : NOP;
      out_addr_o  = in_valid_i ? in_addr_i : '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push && !w_byp_take) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en)               r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_ifu_idu_queue.sv
module tb_ifu_idu_queue;
  import ifu_idu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_inst_i = '0;
  logic [31:0] in_addr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_inst_o;
  logic [31:0] out_addr_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  ifu_idu_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_inst_i   (in_inst_i),
    .in_addr_i   (in_addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_inst_o  (out_inst_o),
    .out_addr_o  (out_addr_o),
    .count_o     (count_o)
  );

  // Reference model: the queue contents as an ordered list of entries.
  ifu_idu_entry_t sb[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, well away from posedge.
  task automatic mon_check();
    int n;
    bit ev;
    n = sb.size();
    chk("count", 32'(count_o), 32'(n));
    chk("in_ready", 32'(in_ready_o), 32'(n != DEPTH));
`ifdef IFU_IDU_BYPASS_EN
    ev = (n == 0 && !flush_i) ? in_valid_i : (n != 0);
`else
    ev = (n != 0);
`endif
    chk("out_valid", 32'(out_valid_o), 32'(ev));
    if (!ev) begin
      chk("idle_inst", out_inst_o, INST_NOP);
      chk("idle_addr", out_addr_o, 32'h0);
    end else if (n == 0) begin
      chk("bypass_inst", out_inst_o, in_inst_i);
      chk("bypass_addr", out_addr_o, in_addr_i);
    end else begin
      chk("head_inst", out_inst_o, sb[0].inst);
      chk("head_addr", out_addr_o, sb[0].addr);
      if (out_ready_i && !flush_i) void'(sb.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) mon_check();
    end
  end

  // Driver: applies one cycle of stimulus and records what the queue should accept.
  task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] addr,
                     input bit rdy, input bit fl, input bit rs);
    int n;
    bit acc;
    @(negedge clk);
    in_valid_i  = v;
    in_inst_i   = inst;
    in_addr_i   = addr;
    out_ready_i = rdy;
    flush_i     = fl;
    rst         = rs;
    n   = sb.size();
    acc = v && (n != DEPTH) && !fl && !rs;
`ifdef IFU_IDU_BYPASS_EN
    if (n == 0 && v && rdy && !fl) acc = 1'b0;
`endif
    #4;
    if (rs || fl) sb.delete();
    else if (acc) sb.push_back('{inst: inst, addr: addr});
  endtask

  // Registered state just after the rising edge that follows a cyc().
  task automatic post(input string name, input int cnt, input bit rdy);
    @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(count_o), 32'(cnt));
    chk({name, "_in_ready"}, 32'(in_ready_o), 32'(rdy));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Reset mid-fill
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 32'h100 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    post("rst", 0, 1'b1);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_out_inst", out_inst_o, 32'h13);
    chk("rst_out_addr", out_addr_o, 32'h0);

    // Fill and backpressure, then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 32'h1000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    post("full", 4, 1'b0);
    drain(4);
    post("drained", 0, 1'b1);

    // Steady push+pop across pointer wrap
    cyc(1'b1, $urandom, 32'h3000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 32'h3004, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, $urandom, 32'h3008 + 32'(4*i), 1'b1, 1'b0, 1'b0);
      post("wrap", 2, 1'b1);
    end
    drain(2);

    // Flush with simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 32'h4000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD0_BAD0, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0);
    post("flush", 0, 1'b1);
`ifndef IFU_IDU_BYPASS_EN
    chk("flush_out_valid", 32'(out_valid_o), 32'h0);
`endif
    drain(3);

    // Latency from an empty queue
    cyc(1'b1, 32'h0000_2013, 32'h2000, 1'b1, 1'b0, 1'b0);
`ifdef IFU_IDU_BYPASS_EN
    post("lat", 0, 1'b1);
`else
    post("lat", 1, 1'b1);
    chk("lat_out_valid", 32'(out_valid_o), 32'h1);
    chk("lat_out_addr", out_addr_o, 32'h2000);
`endif
    drain(2);

    // Full with simultaneous pop and offered input
    for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 32'h6000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 32'h6010, 1'b1, 1'b0, 1'b0);
    post("fullpop", 3, 1'b1);
    drain(4);

    // Randomized traffic
    a = 32'h8000;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, a, $urandom_range(0, 9) < 6,
          $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      a = a + 32'd4;
    end
    drain(6);
    post("final", 0, 1'b1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
